param_cache: RTL and testbench

Parametrised direct-mapped write-back cache between the CPU port and the SDRAM controller. It generalises the fixed 256-byte cache to configurable word width, line length and line count. It adds multi-word line bursts, per-line valid/dirty/tag state, write-allocate, and victim write-back. It also adds a waited SDRAM handshake, so the SDRAM controller may stall any beat.

---
 rtl/param_cache.sv | 184 ++++++++++++++++++
 tb/tb_param_cache.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_cache.sv
// Direct-mapped write-back, write-allocate cache between a CPU port and a waited SDRAM port.
// Lines move as in-order multi-beat bursts; a dirty victim is written back before the refill.
module param_cache #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int LINE_WORDS = 8,
  parameter int NUM_LINES  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  input  logic              cpu_cs,
  input  logic              cpu_wr_rd,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_rdy,
  output logic              cpu_hit,
  input  logic [DATA_W-1:0] sdram_din,
  input  logic              sdram_ack,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dout,
  output logic              sdram_wr_rd,
  output logic              sdram_mstrb
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RESP} state_t;

  state_t state, state_next;

  logic [TAG_W-1:0]  tag_r;
  logic [IDX_W-1:0]  idx_r;
  logic [OFF_W-1:0]  off_r;
  logic [DATA_W-1:0] din_r;
  logic              wr_r;
  logic              miss_r;
  logic [OFF_W-1:0]  beat, beat_next;

  logic [DATA_W-1:0]    data_mem [NUM_LINES][LINE_WORDS];
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid, dirty;

  logic              hit, beat_done, last;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] dout_nx;
  logic              wr_nx, mstrb_nx, rdy_nx, hit_nx;

  assign hit       = valid[idx_r] && (tag_mem[idx_r] == tag_r);
  // An ack only counts while a beat is actually being requested.
  assign beat_done = sdram_mstrb && sdram_ack;
  assign last      = (beat == LAST_BEAT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    beat_next  = beat;
    case (state)
      IDLE:   if (cpu_cs) state_next = LOOKUP;
      LOOKUP: begin
        if (hit) begin
          state_next = RESP;
        end else begin
          beat_next  = '0;
          state_next = (valid[idx_r] && dirty[idx_r]) ? WB : FILL;
        end
      end
      WB: if (beat_done) begin
        beat_next = beat + 1'b1;
        if (last) state_next = FILL;
      end
      FILL: if (beat_done) begin
        beat_next = beat + 1'b1;
        if (last) state_next = LOOKUP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state, so a beat's fields stay put until its ack.
  always_comb begin
    addr_nx  = sdram_addr;
    dout_nx  = sdram_dout;
    wr_nx    = sdram_wr_rd;
    mstrb_nx = 1'b0;
    rdy_nx   = 1'b0;
    hit_nx   = 1'b0;
    case (state_next)
      WB: begin
        addr_nx  = {tag_mem[idx_r], idx_r, beat_next};
        dout_nx  = data_mem[idx_r][beat_next];
        wr_nx    = 1'b1;
        mstrb_nx = 1'b1;
      end
      FILL: begin
        addr_nx  = {tag_r, idx_r, beat_next};
        wr_nx    = 1'b0;
        mstrb_nx = 1'b1;
      end
      RESP: begin
        rdy_nx = 1'b1;
        hit_nx = !miss_r;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdram_addr  <= '0;
      sdram_dout  <= '0;
      sdram_wr_rd <= 1'b0;
      sdram_mstrb <= 1'b0;
      cpu_rdy     <= 1'b0;
      cpu_hit     <= 1'b0;
      cpu_dout    <= '0;
      valid       <= '0;
      dirty       <= '0;
      miss_r      <= 1'b0;
      tag_r       <= '0;
      idx_r       <= '0;
      off_r       <= '0;
      din_r       <= '0;
      wr_r        <= 1'b0;
    end else begin
      sdram_addr  <= addr_nx;
      sdram_dout  <= dout_nx;
      sdram_wr_rd <= wr_nx;
      sdram_mstrb <= mstrb_nx;
      cpu_rdy     <= rdy_nx;
      cpu_hit     <= hit_nx;
      case (state)
        IDLE: if (cpu_cs) begin
          tag_r  <= cpu_addr[ADDR_W-1 -: TAG_W];
          idx_r  <= cpu_addr[OFF_W +: IDX_W];
          off_r  <= cpu_addr[OFF_W-1:0];
          din_r  <= cpu_din;
          wr_r   <= cpu_wr_rd;
          miss_r <= 1'b0;
        end
        LOOKUP: begin
          if (hit) begin
            if (wr_r) dirty[idx_r] <= 1'b1;
            else      cpu_dout     <= data_mem[idx_r][off_r];
          end else begin
            // The line is being replaced; it must not hit on stale contents mid-refill.
            miss_r       <= 1'b1;
            valid[idx_r] <= 1'b0;
          end
        end
        FILL: if (beat_done && last) begin
          valid[idx_r] <= 1'b1;
          dirty[idx_r] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: data and tag arrays have no reset so they map onto RAM; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (state == LOOKUP && hit && wr_r) data_mem[idx_r][off_r] <= din_r;
    if (state == FILL && beat_done) begin
      data_mem[idx_r][beat] <= sdram_din;
      if (last) tag_mem[idx_r] <= tag_r;
    end
  end

endmodule

// File: tb/tb_param_cache.sv
// Bench for param_cache: an SDRAM responder with programmable ack stalls plus a flat-memory
// and tag/valid/dirty reference model that predicts hits, write-backs and read data.
module tb_param_cache;

  localparam int LW = 8;
  localparam int NL = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic        cpu_cs = 1'b0;
  logic        cpu_wr_rd = 1'b0;
  logic [7:0]  cpu_dout;
  logic        cpu_rdy, cpu_hit;
  logic [7:0]  sdram_din = '0;
  logic        sdram_ack = 1'b0;
  logic [15:0] sdram_addr;
  logic [7:0]  sdram_dout;
  logic        sdram_wr_rd, sdram_mstrb;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } beat_t;

  beat_t      log[$];
  logic [7:0] sdram_mem [65536];
  logic [7:0] gold      [65536];
  bit         m_valid [NL];
  bit         m_dirty [NL];
  int         m_tag   [NL];

  int    delay_mode = 0;
  bit    spurious = 1'b0;
  int    pat_i = 0;
  int    unstable = 0;
  bit    loaded = 1'b0;
  int    wait_cnt = 0;
  beat_t cur;

  param_cache dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_cs(cpu_cs), .cpu_wr_rd(cpu_wr_rd),
    .cpu_dout(cpu_dout), .cpu_rdy(cpu_rdy), .cpu_hit(cpu_hit),
    .sdram_din(sdram_din), .sdram_ack(sdram_ack), .sdram_addr(sdram_addr),
    .sdram_dout(sdram_dout), .sdram_wr_rd(sdram_wr_rd), .sdram_mstrb(sdram_mstrb)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int pick_delay();
    int pat[3] = '{0, 3, 5};
    int d;
    case (delay_mode)
      1:       d = int'($urandom_range(0, 3));
      2:       begin d = pat[pat_i % 3]; pat_i++; end
      default: d = 0;
    endcase
    return d;
  endfunction

  // SDRAM responder: drives ack/din on the falling edge, logs every completed beat.
  always @(negedge clk) begin
    if (rst || !sdram_mstrb) begin
      loaded    = 1'b0;
      sdram_ack = (!rst && spurious) ? 1'($urandom_range(0, 1)) : 1'b0;
      sdram_din = 8'($urandom);
    end else begin
      if (!loaded) begin
        loaded   = 1'b1;
        wait_cnt = pick_delay();
        cur.wr   = sdram_wr_rd;
        cur.addr = sdram_addr;
        cur.data = sdram_dout;
      end else if (sdram_wr_rd !== cur.wr || sdram_addr !== cur.addr ||
                   (cur.wr && sdram_dout !== cur.data)) begin
        unstable++;
      end
      if (wait_cnt == 0) begin
        loaded    = 1'b0;
        sdram_ack = 1'b1;
        if (sdram_wr_rd) begin
          sdram_mem[sdram_addr] = sdram_dout;
        end else begin
          sdram_din = sdram_mem[sdram_addr];
        end
        cur.data = sdram_wr_rd ? sdram_dout : sdram_din;
        log.push_back(cur);
      end else begin
        wait_cnt--;
        sdram_ack = 1'b0;
        sdram_din = 8'($urandom);
      end
    end
  end

  // Reference model: predicts hit/write-back for an access and updates the CPU-visible memory.
  task automatic model(input logic wr, input logic [15:0] a, input logic [7:0] d,
                       output bit h, output bit wb);
    int idx = (int'(a) / LW) % NL;
    int tag = int'(a) / (LW * NL);
    h  = m_valid[idx] && m_tag[idx] == tag;
    wb = !h && m_valid[idx] && m_dirty[idx];
    if (!h) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      m_dirty[idx] = 1'b1;
      gold[a]      = d;
    end
  endtask

  // After reset everything cached is gone, so the CPU sees whatever SDRAM holds.
  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    for (int i = 0; i < 65536; i++) gold[i] = sdram_mem[i];
  endtask

  // Call on a falling edge; returns on a falling edge with the bus idle.
  task automatic do_access(input logic wr, input logic [15:0] a, input logic [7:0] d,
                           output logic [7:0] q, output logic h, output int n);
    log.delete();
    cpu_cs    = 1'b1;
    cpu_wr_rd = wr;
    cpu_addr  = a;
    cpu_din   = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_rdy && n < 3000);
    q = cpu_dout;
    h = cpu_hit;
    if (!cpu_rdy) begin
      total++; bad++;
      $display("FAIL access_timeout: addr=%h no cpu_rdy after %0d cycles", a, n);
    end
    cpu_cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] outs [7];
    string names [7] = '{"cpu_dout", "cpu_rdy", "cpu_hit", "sdram_addr_lo", "sdram_dout",
                         "sdram_wr_rd", "sdram_mstrb"};
    rst = 1'b1;
    repeat (2) @(negedge clk);
    outs[0] = cpu_dout;          outs[1] = 8'(cpu_rdy);     outs[2] = 8'(cpu_hit);
    outs[3] = sdram_addr[7:0] | sdram_addr[15:8];
    outs[4] = sdram_dout;        outs[5] = 8'(sdram_wr_rd); outs[6] = 8'(sdram_mstrb);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (outs[i] !== 8'h00) begin
        bad++;
        $display("FAIL reset_%s: got %h expected 00", names[i], outs[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first_fill();
    logic [7:0] q; logic h; int n; bit eh, ewb;
    model(1'b0, 16'h1234, 8'h00, eh, ewb);
    do_access(1'b0, 16'h1234, 8'h00, q, h, n);
    total++;
    if (log.size() !== 8) begin bad++; $display("FAIL fill_beats: got %0d expected 8", log.size()); end
    for (int i = 0; i < 8 && i < log.size(); i++) begin
      total++;
      if (log[i].wr !== 1'b0 || log[i].addr !== 16'(16'h1230 + i)) begin
        bad++;
        $display("FAIL fill_beat%0d: got wr=%b addr=%h expected wr=0 addr=%h",
                 i, log[i].wr, log[i].addr, 16'(16'h1230 + i));
      end
    end
    total++;
    if (q !== sdram_mem[16'h1234]) begin bad++; $display("FAIL fill_dout: got %h expected %h", q, sdram_mem[16'h1234]); end
    total++;
    if (h !== 1'b0) begin bad++; $display("FAIL fill_hit: got %b expected 0", h); end
    total++;
    if (n != 11) begin bad++; $display("FAIL fill_latency: got %0d expected 11", n); end
  endtask

  task automatic test_hit();
    logic [7:0] q; logic h; int n; bit eh, ewb;
    model(1'b0, 16'h1237, 8'h00, eh, ewb);
    do_access(1'b0, 16'h1237, 8'h00, q, h, n);
    total++;
    if (n != 2) begin bad++; $display("FAIL hit_latency: got %0d expected 2", n); end
    total++;
    if (h !== 1'b1) begin bad++; $display("FAIL hit_flag: got %b expected 1", h); end
    total++;
    if (log.size() != 0) begin bad++; $display("FAIL hit_no_beats: got %0d expected 0", log.size()); end
    total++;
    if (q !== gold[16'h1237]) begin bad++; $display("FAIL hit_dout: got %h expected %h", q, gold[16'h1237]); end
  endtask

  task automatic test_writeback();
    logic [7:0] q; logic h; int n; bit eh, ewb;
    model(1'b1, 16'h1234, 8'hA5, eh, ewb);
    do_access(1'b1, 16'h1234, 8'hA5, q, h, n);
    total++;
    if (h !== 1'b1 || n != 2) begin bad++; $display("FAIL wr_hit: got hit=%b n=%0d expected hit=1 n=2", h, n); end
    model(1'b0, 16'h5634, 8'h00, eh, ewb);
    do_access(1'b0, 16'h5634, 8'h00, q, h, n);
    total++;
    if (log.size() !== 16) begin bad++; $display("FAIL wb_beats: got %0d expected 16", log.size()); end
    for (int i = 0; i < 16 && i < log.size(); i++) begin
      logic [15:0] ea = (i < 8) ? 16'(16'h1230 + i) : 16'(16'h5630 + i - 8);
      total++;
      if (log[i].wr !== (i < 8) || log[i].addr !== ea || (i < 8 && log[i].data !== gold[ea])) begin
        bad++;
        $display("FAIL wb_beat%0d: got wr=%b addr=%h data=%h expected wr=%b addr=%h",
                 i, log[i].wr, log[i].addr, log[i].data, (i < 8), ea);
      end
    end
    total++;
    if (log.size() > 4 && log[4].data !== 8'hA5) begin
      bad++; $display("FAIL wb_beat4_data: got %h expected a5", log[4].data);
    end
    total++;
    if (h !== 1'b0 || q !== gold[16'h5634] || n != 19) begin
      bad++;
      $display("FAIL wb_resp: got hit=%b dout=%h n=%0d expected hit=0 dout=%h n=19", h, q, n, gold[16'h5634]);
    end
  endtask

  task automatic test_write_miss_clean();
    logic [7:0] q; logic h; int n; bit eh, ewb;
    model(1'b1, 16'h0008, 8'h3C, eh, ewb);
    do_access(1'b1, 16'h0008, 8'h3C, q, h, n);
    total++;
    if (log.size() !== 8 || h !== 1'b0 || n != 11) begin
      bad++; $display("FAIL wmiss_fill: got beats=%0d hit=%b n=%0d expected beats=8 hit=0 n=11", log.size(), h, n);
    end
    for (int i = 0; i < log.size(); i++) begin
      total++;
      if (log[i].wr !== 1'b0 || log[i].addr !== 16'(8 + i)) begin
        bad++; $display("FAIL wmiss_beat%0d: got wr=%b addr=%h expected wr=0 addr=%h", i, log[i].wr, log[i].addr, 16'(8 + i));
      end
    end
    model(1'b0, 16'h0008, 8'h00, eh, ewb);
    do_access(1'b0, 16'h0008, 8'h00, q, h, n);
    total++;
    if (q !== 8'h3C || h !== 1'b1) begin bad++; $display("FAIL wmiss_readback: got dout=%h hit=%b expected 3c hit=1", q, h); end
  endtask

  task automatic test_stall();
    logic [7:0] q; logic h; int n; bit eh, ewb;
    model(1'b1, 16'h0009, 8'h77, eh, ewb);
    do_access(1'b1, 16'h0009, 8'h77, q, h, n);
    delay_mode = 2; pat_i = 0; unstable = 0;
    model(1'b0, 16'h7708, 8'h00, eh, ewb);
    do_access(1'b0, 16'h7708, 8'h00, q, h, n);
    total++;
    if (log.size() !== 16 || unstable != 0) begin
      bad++; $display("FAIL stall_beats: got beats=%0d unstable=%0d expected beats=16 unstable=0", log.size(), unstable);
    end
    total++;
    if (n != 59 || h !== 1'b0 || q !== gold[16'h7708]) begin
      bad++; $display("FAIL stall_resp: got n=%0d hit=%b dout=%h expected n=59 hit=0 dout=%h", n, h, q, gold[16'h7708]);
    end
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a = 16'(16'h7708 + i);
      model(1'b0, a, 8'h00, eh, ewb);
      do_access(1'b0, a, 8'h00, q, h, n);
      total++;
      if (q !== gold[a] || h !== 1'b1) begin bad++; $display("FAIL stall_word%0d: got %h hit=%b expected %h hit=1", i, q, h, gold[a]); end
    end
    model(1'b0, 16'h0009, 8'h00, eh, ewb);
    do_access(1'b0, 16'h0009, 8'h00, q, h, n);
    total++;
    if (q !== 8'h77 || h !== 1'b0) begin bad++; $display("FAIL stall_wb_data: got %h hit=%b expected 77 hit=0", q, h); end
    delay_mode = 0;
  endtask

  task automatic test_random();
    int tags[4] = '{'h12, 'h56, 'h9A, 'h00};
    logic [7:0] q; logic h; int n; bit eh, ewb;
    delay_mode = 1; spurious = 1'b1; unstable = 0;
    for (int k = 0; k < 80; k++) begin
      logic [15:0] a = 16'((tags[$urandom_range(0, 3)] << 8) | ($urandom_range(0, 7) << 3) | $urandom_range(0, 7));
      logic        wr = 1'($urandom_range(0, 1));
      logic [7:0]  d = 8'($urandom);
      int          eb;
      model(wr, a, d, eh, ewb);
      eb = eh ? 0 : (ewb ? 16 : 8);
      do_access(wr, a, d, q, h, n);
      total++;
      if (h !== eh || log.size() != eb || (eh && n != 2)) begin
        bad++; $display("FAIL rand%0d_ctrl: addr=%h got hit=%b beats=%0d n=%0d expected hit=%b beats=%0d",
                        k, a, h, log.size(), n, eh, eb);
      end
      if (!wr) begin
        total++;
        if (q !== gold[a]) begin bad++; $display("FAIL rand%0d_data: addr=%h got %h expected %h", k, a, q, gold[a]); end
      end
    end
    total++;
    if (unstable != 0) begin bad++; $display("FAIL rand_stable: got %0d unstable beats expected 0", unstable); end
    delay_mode = 0; spurious = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    logic [7:0] q; logic h; int n; bit eh, ewb;
    log.delete();
    cpu_cs = 1'b1; cpu_wr_rd = 1'b0; cpu_addr = 16'h22A0;
    n = 0;
    while (log.size() < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (log.size() < 4) begin bad++; $display("FAIL midrst_progress: got %0d beats expected 4", log.size()); end
    @(posedge clk);
    #1;
    total++;
    if (sdram_mstrb !== 1'b1) begin bad++; $display("FAIL midrst_pre_mstrb: got %b expected 1", sdram_mstrb); end
    #1 rst = 1'b1;
    cpu_cs = 1'b0;
    #1;
    total++;
    if (sdram_mstrb !== 1'b0) begin bad++; $display("FAIL midrst_mstrb: got %b expected 0", sdram_mstrb); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    model(1'b0, 16'h22A0, 8'h00, eh, ewb);
    do_access(1'b0, 16'h22A0, 8'h00, q, h, n);
    total++;
    if (h !== 1'b0 || log.size() !== 8 || n != 11 || q !== gold[16'h22A0]) begin
      bad++; $display("FAIL midrst_reread: got hit=%b beats=%0d n=%0d dout=%h expected hit=0 beats=8 n=11 dout=%h",
                      h, log.size(), n, q, gold[16'h22A0]);
    end
    total++;
    if (log.size() > 0 && log[0].addr !== 16'h22A0) begin
      bad++; $display("FAIL midrst_first_beat: got %h expected 22a0", log[0].addr);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      sdram_mem[i] = 8'(i ^ (i >> 8) ^ 'h5A);
      gold[i]      = sdram_mem[i];
    end
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 0;
    end
    test_reset();
    test_first_fill();
    test_hit();
    test_writeback();
    test_write_miss_clean();
    test_stall();
    test_random();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
